// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop bounding-box detector.
package crop_pkg;

  localparam int unsigned DATA_W_DEF   = 10;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned WIN_X0_DEF   = 160;
  localparam int unsigned WIN_X1_DEF   = 480;
  localparam int unsigned WIN_Y0_DEF   = 120;
  localparam int unsigned WIN_Y1_DEF   = 190;

  // Box fields are stored at the default coordinate width
  localparam int unsigned BBOX_W = CNT_W_DEF;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    SCAN     = 1'b1
  } state_t;

  typedef struct packed {
    logic [BBOX_W-1:0] ystart;
    logic [BBOX_W-1:0] yend;
    logic [BBOX_W-1:0] xstart;
    logic [BBOX_W-1:0] xend;
    logic              found;
  } bbox_t;

  localparam bbox_t BBOX_CLEAR = '0;

endpackage

// File: rtl/crop_xy_counter.sv
// Raster position counter; resync restarts the count with the current pixel as (0,0).
module crop_xy_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             advance,
  input  logic             resync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_last
);

  logic [CNT_W-1:0] bx;
  logic [CNT_W-1:0] by;
  logic             line_last;

  // Effective position of the pixel being accepted this cycle
  always_comb begin
    bx         = resync ? '0 : x;
    by         = resync ? '0 : y;
    line_last  = (bx == CNT_W'(H_ACTIVE - 1));
    frame_last = line_last && (by == CNT_W'(V_ACTIVE - 1));
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (line_last) begin
        x <= '0;
        y <= frame_last ? '0 : by + CNT_W'(1);
      end else begin
        x <= bx + CNT_W'(1);
        y <= by;
      end
    end
  end

endmodule

// File: rtl/crop_bbox_detect.sv
// Tracks the bounding box of threshold-matching pixels inside a search window
// and publishes it once per frame with a one-cycle valid strobe.
module crop_bbox_detect
  import crop_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned WIN_X0      = WIN_X0_DEF,
  parameter int unsigned WIN_X1      = WIN_X1_DEF,
  parameter int unsigned WIN_Y0      = WIN_Y0_DEF,
  parameter int unsigned WIN_Y1      = WIN_Y1_DEF,
  parameter bit          REQUIRE_SOF = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [DATA_W-1:0] iTHRESH,
  input  logic              iPOL,
  output logic [CNT_W-1:0]  oYSTART,
  output logic [CNT_W-1:0]  oYEND,
  output logic [CNT_W-1:0]  oXSTART,
  output logic [CNT_W-1:0]  oXEND,
  output logic              oFOUND,
  output logic              oVALID,
  output logic              oSYNCED
);

  state_t           state;
  state_t           next_state;
  logic             sof_pix;
  logic             advance;
  logic             frame_last;
  logic             in_win;
  logic             hit;
  logic             match;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] px;
  logic [CNT_W-1:0] py;
  bbox_t            acc;
  bbox_t            base;
  bbox_t            upd;
  bbox_t            pub;
  logic             valid;

  assign sof_pix = iDVAL & iSOF;

  crop_xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_xy (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .advance    (advance),
    .resync     (sof_pix),
    .x          (x),
    .y          (y),
    .frame_last (frame_last)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST) state <= REQUIRE_SOF ? WAIT_SOF : SCAN;
    else       state <= next_state;
  end

  // Pixels are only accepted once aligned; an SOF pixel aligns and is accepted
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (sof_pix) begin
          next_state = SCAN;
          advance    = 1'b1;
        end
      end
      SCAN:     advance = iDVAL;
      default:  next_state = state;
    endcase
  end

  // Match classification and accumulator update for the current pixel
  always_comb begin
    px     = sof_pix ? '0 : x;
    py     = sof_pix ? '0 : y;
    in_win = (px >= CNT_W'(WIN_X0)) && (px <= CNT_W'(WIN_X1)) &&
             (py >= CNT_W'(WIN_Y0)) && (py <= CNT_W'(WIN_Y1));
    hit    = iPOL ? (iDATA >= iTHRESH) : (iDATA <= iTHRESH);
    match  = in_win && hit;
    base   = sof_pix ? BBOX_CLEAR : acc;
    upd    = base;
    if (match) begin
      if (!base.found) begin
        upd.ystart = BBOX_W'(py);
        upd.yend   = BBOX_W'(py);
        upd.xstart = BBOX_W'(px);
        upd.xend   = BBOX_W'(px);
        upd.found  = 1'b1;
      end else begin
        upd.yend = BBOX_W'(py);
        if (BBOX_W'(px) < base.xstart) upd.xstart = BBOX_W'(px);
        if (BBOX_W'(px) > base.xend)   upd.xend   = BBOX_W'(px);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      acc   <= BBOX_CLEAR;
      pub   <= BBOX_CLEAR;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (advance) begin
        if (frame_last) begin
          pub   <= upd;
          valid <= 1'b1;
          acc   <= BBOX_CLEAR;
        end else begin
          acc <= upd;
        end
      end
    end
  end

  assign oYSTART = CNT_W'(pub.ystart);
  assign oYEND   = CNT_W'(pub.yend);
  assign oXSTART = CNT_W'(pub.xstart);
  assign oXEND   = CNT_W'(pub.xend);
  assign oFOUND  = pub.found;
  assign oVALID  = valid;
  assign oSYNCED = (state == SCAN);

endmodule

// File: tb/tb_crop_bbox_detect.sv
// Scoreboard bench for crop_bbox_detect on a scaled-down 64x48 raster.
`timescale 1ns/1ps
module tb_crop_bbox_detect;

  localparam int DW = 10;
  localparam int CW = 16;
  localparam int H  = 64;
  localparam int V  = 48;
  localparam int X0 = 16;
  localparam int X1 = 48;
  localparam int Y0 = 12;
  localparam int Y1 = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          dval;
  logic          sof;
  logic [DW-1:0] data;
  logic [DW-1:0] thresh;
  logic          pol;
  logic [CW-1:0] ystart, yend, xstart, xend;
  logic          found, valid, synced;

  typedef struct {
    int ys;
    int ye;
    int xs;
    int xe;
    bit f;
  } box_t;

  box_t          sb[$];
  box_t          last_box;
  int            mx[$];
  int            my[$];
  logic [DW-1:0] hit_val;
  logic [DW-1:0] miss_val;
  int            passed = 0;
  int            total  = 0;
  int            vcount = 0;

  always #5 clk = ~clk;

  crop_bbox_detect #(
    .DATA_W(DW), .CNT_W(CW), .H_ACTIVE(H), .V_ACTIVE(V),
    .WIN_X0(X0), .WIN_X1(X1), .WIN_Y0(Y0), .WIN_Y1(Y1), .REQUIRE_SOF(1'b1)
  ) dut (
    .iCLK(clk), .iRST(rst), .iDVAL(dval), .iSOF(sof), .iDATA(data),
    .iTHRESH(thresh), .iPOL(pol),
    .oYSTART(ystart), .oYEND(yend), .oXSTART(xstart), .oXEND(xend),
    .oFOUND(found), .oVALID(valid), .oSYNCED(synced)
  );

  // Expected box: min/max over listed match pixels that fall inside the window
  function automatic box_t model_box();
    box_t b;
    bit   m;
    b = '{0, 0, 0, 0, 1'b0};
    m = pol ? (hit_val >= thresh) : (hit_val <= thresh);
    for (int i = 0; i < mx.size(); i++) begin
      if (m && mx[i] >= X0 && mx[i] <= X1 && my[i] >= Y0 && my[i] <= Y1) begin
        if (!b.f) b = '{my[i], my[i], mx[i], mx[i], 1'b1};
        else begin
          if (my[i] < b.ys) b.ys = my[i];
          if (my[i] > b.ye) b.ye = my[i];
          if (mx[i] < b.xs) b.xs = mx[i];
          if (mx[i] > b.xe) b.xe = mx[i];
        end
      end
    end
    return b;
  endfunction

  function automatic bit is_hit(input int xx, input int yy);
    for (int i = 0; i < mx.size(); i++)
      if (mx[i] == xx && my[i] == yy) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard consumer: every oVALID pops and checks one expected box
  always @(negedge clk) begin
    box_t e;
    if (valid === 1'b1) begin
      vcount++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: oVALID=1 at %0t, required no publish", $time);
      end else begin
        e = sb.pop_front();
        if (ystart !== CW'(e.ys) || yend !== CW'(e.ye) || xstart !== CW'(e.xs) ||
            xend !== CW'(e.xe) || found !== e.f)
          $display("FAIL publish_box: got y=%0d..%0d x=%0d..%0d found=%0b, required y=%0d..%0d x=%0d..%0d found=%0b",
                   ystart, yend, xstart, xend, found, e.ys, e.ye, e.xs, e.xe, e.f);
        else passed++;
      end
    end
  end

  // Drive rows [start_row, stop_row) with optional random iDVAL gaps
  task automatic run_frame(input bit with_sof, input int gap_pct, input int start_row,
                           input int stop_row, input bit expect_pub);
    bit first = 1'b1;
    bit last;
    for (int yy = start_row; yy < stop_row; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          @(posedge clk); #1;
        end
        last  = (xx == H - 1) && (yy == V - 1);
        dval  = 1'b1;
        sof   = with_sof && first;
        first = 1'b0;
        data  = is_hit(xx, yy) ? hit_val : miss_val;
        if (expect_pub && last) begin
          last_box = model_box();
          sb.push_back(last_box);
        end
        @(posedge clk); #1;
        dval = 1'b0;
        sof  = 1'b0;
        if (expect_pub && last) begin
          total++;
          if (valid !== 1'b1) $display("FAIL publish_latency: oVALID=%0b after final pixel, required 1", valid);
          else passed++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; dval = 1'b0; sof = 1'b0; data = '0; thresh = '0; pol = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ystart, yend, xstart, xend} !== '0) $display("FAIL reset_coords: got %0d %0d %0d %0d, required all 0", ystart, yend, xstart, xend);
    else passed++;
    total++;
    if ({found, valid} !== 2'b00) $display("FAIL reset_flags: found=%0b valid=%0b, required 0 0", found, valid);
    else passed++;
    total++;
    if (synced !== 1'b0) $display("FAIL reset_synced: got %0b, required 0", synced);
    else passed++;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_dark_box();
    thresh = '0; pol = 1'b0; hit_val = '0; miss_val = 10'd1023;
    mx = '{20, 30, 25}; my = '{13, 15, 18};
    run_frame(1'b1, 0, 0, V, 1'b1);
    total++;
    if (synced !== 1'b1) $display("FAIL synced_scan: got %0b, required 1", synced);
    else passed++;
    idle(5);
    total++;
    if (ystart !== 16'd13 || yend !== 16'd18 || xstart !== 16'd20 || xend !== 16'd30 || found !== 1'b1)
      $display("FAIL hold_dark_box: got y=%0d..%0d x=%0d..%0d found=%0b, required 13..18 20..30 1",
               ystart, yend, xstart, xend, found);
    else passed++;
  endtask

  task automatic test_outside();
    mx = '{10, 20}; my = '{13, 20};
    run_frame(1'b1, 0, 0, V, 1'b1);
    idle(2);
    total++;
    if ({ystart, yend, xstart, xend} !== '0 || found !== 1'b0)
      $display("FAIL outside_window: got %0d %0d %0d %0d found=%0b, required 0 0 0 0 0",
               ystart, yend, xstart, xend, found);
    else passed++;
  endtask

  task automatic test_corners();
    thresh = 10'd900; pol = 1'b1; hit_val = 10'd950; miss_val = '0;
    mx = '{16, 48, 15, 49, 16, 48}; my = '{12, 19, 12, 19, 11, 20};
    run_frame(1'b1, 0, 0, V, 1'b1);
    idle(2);
    total++;
    if (ystart !== 16'd12 || yend !== 16'd19 || xstart !== 16'd16 || xend !== 16'd48)
      $display("FAIL window_corners: got y=%0d..%0d x=%0d..%0d, required 12..19 16..48",
               ystart, yend, xstart, xend);
    else passed++;
  endtask

  task automatic test_resync();
    int v0;
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    thresh = '0; pol = 1'b0; hit_val = '0; miss_val = 10'd1023;
    v0 = vcount;
    mx = '{20}; my = '{2};
    run_frame(1'b0, 0, 0, 5, 1'b0);
    total++;
    if (synced !== 1'b0 || vcount != v0) $display("FAIL pre_sof: synced=%0b pulses=%0d, required 0 0", synced, vcount - v0);
    else passed++;
    mx = '{20, 40}; my = '{13, 17};
    run_frame(1'b1, 0, 0, 30, 1'b0);
    total++;
    if (synced !== 1'b1) $display("FAIL sof_sync: synced=%0b, required 1", synced);
    else passed++;
    mx = '{30}; my = '{14};
    run_frame(1'b1, 0, 0, V, 1'b1);
    idle(2);
    total++;
    if (vcount != v0 + 1 || ystart !== 16'd14 || xstart !== 16'd30 || xend !== 16'd30)
      $display("FAIL midframe_sof: pulses=%0d y=%0d x=%0d..%0d, required 1 14 30..30",
               vcount - v0, ystart, xstart, xend);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcount;
    mx = '{20, 30, 25}; my = '{13, 15, 18};
    run_frame(1'b1, 50, 0, V, 1'b1);
    run_frame(1'b0, 50, 0, V, 1'b1);
    idle(3);
    total++;
    if (vcount != v0 + 2) $display("FAIL back_to_back_pulses: got %0d, required 2", vcount - v0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int v0;
    run_frame(1'b1, 0, 0, 30, 1'b0);
    v0 = vcount;
    rst = 1'b0; @(posedge clk); #1;
    total++;
    if ({ystart, yend, xstart, xend} !== '0 || {found, valid, synced} !== 3'b000)
      $display("FAIL reset_midframe: got %0d %0d %0d %0d f=%0b v=%0b s=%0b, required all 0",
               ystart, yend, xstart, xend, found, valid, synced);
    else passed++;
    rst = 1'b1;
    run_frame(1'b0, 0, 30, V, 1'b0);
    idle(3);
    total++;
    if (vcount != v0 || found !== 1'b0) $display("FAIL reset_no_publish: pulses=%0d found=%0b, required 0 0", vcount - v0, found);
    else passed++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dark_box();
    test_outside();
    test_corners();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d expected boxes never published, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
